// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encodings, FSM states and counter sizing for muldiv_seq
package muldiv_pkg;
  localparam logic [1:0] OP_MUL = 2'b00, OP_DIV = 2'b01, OP_MULU = 2'b10, OP_DIVU = 2'b11;
  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one Booth add/sub-and-shift (mode=0) or restoring subtract-and-shift (mode=1)
module muldiv_step #(parameter int WIDTH = 32) (
  input  logic             mode,
  input  logic [WIDTH+1:0] acc,
  input  logic [WIDTH+1:0] m,
  input  logic [WIDTH-1:0] q,
  input  logic             q1,
  output logic [WIDTH+1:0] nacc,
  output logic [WIDTH-1:0] nq,
  output logic             nq1
);
  logic [WIDTH+1:0] sum, sh, diff;
  always_comb begin
    sum  = (q[0] ^ q1) ? (q[0] ? acc - m : acc + m) : acc;
    sh   = {acc[WIDTH:0], q[WIDTH-1]};
    diff = sh - m;
    nacc = mode ? (diff[WIDTH+1] ? sh : diff) : {sum[WIDTH+1], sum[WIDTH+1:1]};
    nq   = mode ? {q[WIDTH-2:0], ~diff[WIDTH+1]} : {sum[0], q[WIDTH-1:1]};
    nq1  = mode ? 1'b0 : q[0];
  end
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle Booth multiply / restoring divide with Start/Busy/Done handshake.
// Define MULDIV_UNSIGNED_EN to let Op[1] select the unsigned MULU/DIVU paths.
module muldiv_seq import muldiv_pkg::*; #(parameter int WIDTH = 32) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             DivByZero
);
  localparam int CW = cnt_w(WIDTH);
  state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH+1:0] acc, m, nacc;
  logic [WIDTH-1:0] q, nq, a_r, abs_a, abs_b;
  logic q1, nq1, corr, neg_q, neg_r, dz, uns_in, sa, sb;
`ifdef MULDIV_UNSIGNED_EN
  assign uns_in = Op[1];
`else
  logic unused_op;
  assign unused_op = Op[1];
  assign uns_in = 1'b0;
`endif
  assign sa = ~uns_in & A[WIDTH-1];
  assign sb = ~uns_in & B[WIDTH-1];
  assign abs_a = sa ? -A : A;
  assign abs_b = sb ? -B : B;
  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .mode(state == S_DIV), .acc(acc), .m(m), .q(q), .q1(q1),
    .nacc(nacc), .nq(nq), .nq1(nq1)
  );
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state <= S_IDLE; cnt <= '0; acc <= '0; m <= '0; q <= '0; q1 <= 1'b0; a_r <= '0;
      corr <= 1'b0; neg_q <= 1'b0; neg_r <= 1'b0; dz <= 1'b0;
      Busy <= 1'b0; Done <= 1'b0; Hi <= '0; Lo <= '0; DivByZero <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        S_IDLE: if (Start) begin
          Busy <= 1'b1; DivByZero <= 1'b0; cnt <= '0; a_r <= A; q1 <= 1'b0;
          // Booth over WIDTH bits reads an unsigned multiplier's MSB as negative; corr adds A back into Hi
          corr <= ~Op[0] & uns_in & B[WIDTH-1];
          dz <= Op[0] && B == '0;
          neg_q <= Op[0] & (sa ^ sb);
          neg_r <= Op[0] & sa;
          if (!Op[0]) begin
            state <= S_MUL; acc <= '0; q <= B;
            m <= uns_in ? {2'b0, A} : {{2{A[WIDTH-1]}}, A};
          end else if (B == '0) begin
            state <= S_DONE; acc <= {2'b0, A}; q <= '1;
          end else begin
            state <= S_DIV; acc <= '0; q <= abs_a; m <= {2'b0, abs_b};
          end
        end
        S_MUL, S_DIV: begin
          acc <= nacc; q <= nq; q1 <= nq1; cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= (state == S_MUL) ? S_DONE : S_FIX;
        end
        S_FIX: begin
          acc <= neg_r ? -acc : acc;
          q <= neg_q ? -q : q;
          state <= S_DONE;
        end
        S_DONE: begin
          Hi <= acc[WIDTH-1:0] + (corr ? a_r : '0);
          Lo <= q; Done <= 1'b1; Busy <= 1'b0; DivByZero <= dz; cnt <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
